// File: rtl/full_adder_ha_pkg.sv
// full_adder_ha_pkg: shared constants and golden model for the half-adder
// based ripple-carry adder.
//   MAX_WIDTH - widest supported operand width
//   ref_add   - exact (a + b + cin) over MAX_WIDTH+1 bits; callers zero-extend
//               narrower operands and read bit WIDTH as the carry out.
package full_adder_ha_pkg;

    localparam int MAX_WIDTH = 64;

    function automatic logic [MAX_WIDTH:0] ref_add(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input logic                 cin
    );
        return {1'b0, a} + {1'b0, b} + {{MAX_WIDTH{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/full_adder_ha_half_adder.sv
// half_adder: single-bit half adder cell.
//   x, y - input bits
//   s    - x ^ y
//   c    - x & y
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/full_adder_ha.sv
// full_adder_ha: registered WIDTH-bit ripple-carry adder built from half
// adders (two per bit, carry merged with an OR). One cycle latency.
//   clk, rst           - clock, synchronous active-high reset
//   in_valid, a, b,    - operands accepted on every edge with in_valid=1
//   carry_in
//   out_valid          - 1 for the cycle after an accepted input
//   sum, carry_out     - registered result; held while no input is accepted
//   ovf                - signed overflow, only when FULL_ADDER_HA_OVF_EN is
//                        defined
module full_adder_ha
    import full_adder_ha_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
`ifdef FULL_ADDER_HA_OVF_EN
    output logic             ovf,
`endif
    output logic             carry_out
);

    // c[i] is the carry into bit i; c[0] is the external carry in.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] c1;
    logic [WIDTH-1:0] c2;

    assign c[0] = carry_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        half_adder u_ha1 (.x(a[i]),  .y(b[i]), .s(s1[i]), .c(c1[i]));
        half_adder u_ha2 (.x(s1[i]), .y(c[i]), .s(s[i]),  .c(c2[i]));
        // Both half-adder carries can never be 1 together, so OR is exact.
        assign c[i+1] = c1[i] | c2[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            carry_out <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            sum       <= s;
            carry_out <= c[WIDTH];
            out_valid <= 1'b1;
        end else begin
            // Result held; inputs (possibly X) are ignored.
            out_valid <= 1'b0;
        end
    end

`ifdef FULL_ADDER_HA_OVF_EN
    // Signed overflow: carry into MSB differs from carry out of MSB.
    // For WIDTH=1, c[WIDTH-1] is carry_in.
    always_ff @(posedge clk) begin
        if (rst)           ovf <= 1'b0;
        else if (in_valid) ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
`endif

endmodule

// File: tb/tb_full_adder_ha.sv
// tb_full_adder_ha: directed + randomized check of full_adder_ha at WIDTH=1
// and WIDTH=8, sharing one clock and reset.
module tb_full_adder_ha;
    import full_adder_ha_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, ci1 = 1'b0;
    logic       ov1, s1, co1;
    logic       v8 = 1'b0, ci8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ov8, co8;
    logic [7:0] s8;
`ifdef FULL_ADDER_HA_OVF_EN
    logic       of1, of8;
`endif

    full_adder_ha #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .carry_in(ci1),
        .out_valid(ov1), .sum(s1),
`ifdef FULL_ADDER_HA_OVF_EN
        .ovf(of1),
`endif
        .carry_out(co1));

    full_adder_ha #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .carry_in(ci8),
        .out_valid(ov8), .sum(s8),
`ifdef FULL_ADDER_HA_OVF_EN
        .ovf(of8),
`endif
        .carry_out(co8));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge, results are read on the next one.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk8(input string tag, input logic [8:0] exp, input logic ev);
        chk({tag, ".sum"}, {57'b0, s8}, {57'b0, exp[7:0]});
        chk({tag, ".cout"}, {64'b0, co8}, {64'b0, exp[8]});
        chk({tag, ".valid"}, {64'b0, ov8}, {64'b0, ev});
    endtask

    task automatic chk1(input string tag, input logic [1:0] exp, input logic ev);
        chk({tag, ".sum"}, {64'b0, s1}, {64'b0, exp[0]});
        chk({tag, ".cout"}, {64'b0, co1}, {64'b0, exp[1]});
        chk({tag, ".valid"}, {64'b0, ov1}, {64'b0, ev});
    endtask

    logic [MAX_WIDTH:0] r;
    logic [8:0]         e8;
    logic               eovf8;

    initial begin
        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk1("rst_w1", 2'b00, 1'b0);
        chk8("rst_w8", 9'h000, 1'b0);
`ifdef FULL_ADDER_HA_OVF_EN
        chk("rst_ovf8", {64'b0, of8}, 65'd0);
`endif
        rst = 1'b0;
        tick();

        // WIDTH=1: 0+0+1
        v1 = 1'b1; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b1;
        tick();
        chk1("w1_001", 2'b01, 1'b1);

        // WIDTH=1 back-to-back
        a1 = 1'b0; b1 = 1'b1; ci1 = 1'b1; tick(); chk1("w1_011", 2'b10, 1'b1);
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1; tick(); chk1("w1_111", 2'b11, 1'b1);
        a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0; tick(); chk1("w1_000", 2'b00, 1'b1);
        v1 = 1'b0;

        // WIDTH=8 boundaries
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1;
        tick(); chk8("w8_ff_00_1", 9'h100, 1'b1);
`ifdef FULL_ADDER_HA_OVF_EN
        chk("w8_ff_00_1.ovf", {64'b0, of8}, 65'd0);
`endif
        a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0;
        tick(); chk8("w8_7f_01_0", 9'h080, 1'b1);
`ifdef FULL_ADDER_HA_OVF_EN
        chk("w8_7f_01_0.ovf", {64'b0, of8}, 65'd1);
`endif
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
        tick(); chk8("w8_all_ones", 9'h1FF, 1'b1);
        a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0;
        tick(); chk8("w8_7f_01_0b", 9'h080, 1'b1);

        // Hold with X on inputs while invalid
        v8 = 1'b0; a8 = 'x; b8 = 'x; ci8 = 1'bx;
        tick(); chk8("hold1", 9'h080, 1'b0);
        tick(); chk8("hold2", 9'h080, 1'b0);
`ifdef FULL_ADDER_HA_OVF_EN
        chk("hold.ovf", {64'b0, of8}, 65'd1);
`endif

        // Reset overrides a valid input
        rst = 1'b1; v8 = 1'b1; a8 = 8'd3; b8 = 8'd4; ci8 = 1'b0;
        tick(); chk8("rst_drop", 9'h000, 1'b0);
        rst = 1'b0; v8 = 1'b0;
        tick(); chk8("post_rst_idle", 9'h000, 1'b0);
        v8 = 1'b1;
        tick(); chk8("post_rst_3p4", 9'h007, 1'b1);
        v8 = 1'b0;

        // WIDTH=1 exhaustive
        v1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a1 = i[2]; b1 = i[1]; ci1 = i[0];
            tick();
            r = ref_add({63'b0, a1}, {63'b0, b1}, ci1);
            chk1("w1_exh", r[1:0], 1'b1);
`ifdef FULL_ADDER_HA_OVF_EN
            chk("w1_exh.ovf", {64'b0, of1}, {64'b0, (a1 == b1) && (s1 != a1)});
`endif
        end
        v1 = 1'b0;

        // WIDTH=8 randomized against ref_add, with idle cycles mixed in
        e8 = 9'h007; eovf8 = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            v8 = ($urandom_range(0, 7) != 0);
            if (v8) begin
                a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
                r = ref_add({56'b0, a8}, {56'b0, b8}, ci8);
                e8 = r[8:0];
                eovf8 = (a8[7] == b8[7]) && (e8[7] != a8[7]);
            end else begin
                a8 = 'x; b8 = 'x; ci8 = 1'bx;
            end
            tick();
            chk8("w8_rand", e8, v8);
`ifdef FULL_ADDER_HA_OVF_EN
            chk("w8_rand.ovf", {64'b0, of8}, {64'b0, eovf8});
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
